// File: rtl/cplx_mm_pkg.sv
// Shared definitions for the complex matrix multiplier and its result serializer.
// Holds the default bundle geometry, the serializer state type and a small
// helper that sizes element-index counters.
package cplx_mm_pkg;

    // Complex elements per result bundle.
    localparam int CPLX_SIZE  = 16;
    // Bits per real or imaginary component (IEEE-754 binary64).
    localparam int CPLX_WIDTH = 64;

    // Serializer states: IDLE waits for a bundle, STREAM holds one and emits beats.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } cplx_ser_state_t;

    // Width of an index that counts 0..n-1, kept at least one bit wide.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/complex_result_serializer.sv
// complex_result_serializer
// Accepts a whole bundle of SIZE complex results in one handshake and
// streams it out one element per beat, real and imaginary side by side.
// A new bundle can be taken on the cycle the last beat leaves, so
// back-to-back bundles stream without a bubble.
// Optional feature: define CPLX_SER_FLUSH_EN to add the flush_i abort input.
module complex_result_serializer
    import cplx_mm_pkg::*;
#(
    parameter int  SIZE  = CPLX_SIZE,
    parameter int  WIDTH = CPLX_WIDTH,
    localparam int IDX_W = idx_width(SIZE)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
`ifdef CPLX_SER_FLUSH_EN
    input  logic                          flush_i,
`endif
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [2*SIZE-1:0][WIDTH-1:0]  result_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [WIDTH-1:0]              out_real_o,
    output logic [WIDTH-1:0]              out_imag_o,
    output logic [IDX_W-1:0]              out_idx_o,
    output logic                          out_last_o,
    output logic                          busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    cplx_ser_state_t              r_state;
    logic [IDX_W-1:0]             r_idx;
    logic [2*SIZE-1:0][WIDTH-1:0] r_buf;
    logic                         r_out_valid;
    logic                         r_out_last;

    logic                         w_flush;
    logic                         w_at_last;
    logic                         w_beat;
    logic                         w_in_ready;
    logic                         w_accept;
    logic [IDX_W-1:0]             w_next_idx;
    logic [IDX_W:0]               w_re_sel;
    logic [IDX_W:0]               w_im_sel;

`ifdef CPLX_SER_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    assign w_at_last  = (r_idx == LAST_IDX);
    assign w_beat     = r_out_valid && out_ready_i;
    assign w_next_idx = r_idx + IDX_W'(1);

    // The upstream may hand over a new bundle while idle, or on the very
    // cycle the last element is taken; a flush blocks acceptance outright.
    assign w_in_ready = !w_flush && ((r_state == IDLE) || (w_at_last && out_ready_i));
    assign w_accept   = in_valid_i && w_in_ready;

    // Element i sits at words 2*i (real) and 2*i+1 (imaginary).
    assign w_re_sel = {r_idx, 1'b0};
    assign w_im_sel = {r_idx, 1'b1};

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_last_o  = r_out_last;
    assign out_idx_o   = r_idx;
    assign out_real_o  = r_buf[w_re_sel];
    assign out_imag_o  = r_buf[w_im_sel];
    assign busy_o      = (r_state == STREAM);

    // Serializer FSM: bundle capture, beat sequencing and registered handshake flags.
    // NOTE: every register here is assigned with <= so all updates see the
    // pre-edge values of their neighbours; blocking = would create ordering races.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            // NOTE: the bundle buffer is deliberately reset so the data outputs
            // read zero out of reset; this costs reset fan-out on every bit.
            r_buf       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_flush) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            // Covers both a fresh start and the zero-bubble handover on the last beat.
            r_state     <= STREAM;
            r_idx       <= '0;
            r_buf       <= result_i;
            r_out_valid <= 1'b1;
            r_out_last  <= (SIZE == 1);
        end else if (w_beat) begin
            if (w_at_last) begin
                r_state     <= IDLE;
                r_idx       <= '0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                r_idx      <= w_next_idx;
                r_out_last <= (w_next_idx == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_complex_result_serializer.sv
// Self-checking bench for complex_result_serializer.
// A queue of pending beats stands in for the design: an accepted bundle
// appends SIZE beats, every taken beat pops one, and the design must show
// the queue head on its outputs each cycle.
// Define CPLX_SER_FLUSH_EN for both RTL and bench to include the flush scenario.
module tb_complex_result_serializer;

    localparam int SIZE  = 16;
    localparam int WIDTH = 64;
    localparam int IDX_W = 4;

    logic                         clk_i = 1'b0;
    logic                         rst_ni = 1'b0;
    logic                         flush_v = 1'b0;
    logic                         in_valid_i = 1'b0;
    logic                         in_ready_o;
    logic [2*SIZE-1:0][WIDTH-1:0] result_i = '0;
    logic                         out_valid_o;
    logic                         out_ready_i = 1'b0;
    logic [WIDTH-1:0]             out_real_o;
    logic [WIDTH-1:0]             out_imag_o;
    logic [IDX_W-1:0]             out_idx_o;
    logic                         out_last_o;
    logic                         busy_o;

    complex_result_serializer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
`ifdef CPLX_SER_FLUSH_EN
        .flush_i     (flush_v),
`endif
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .result_i    (result_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_real_o  (out_real_o),
        .out_imag_o  (out_imag_o),
        .out_idx_o   (out_idx_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        int               idx;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    dut_beats = 0;
    bit    last_push = 1'b0;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the design against the queue head, then advance one clock.
    task automatic cycle();
        bit    exp_valid;
        bit    exp_rdy;
        bit    do_pop;
        bit    do_push;
        logic [2*SIZE-1:0][WIDTH-1:0] snap;
        beat_t b;
        #1;
        exp_valid = (q.size() > 0);
        exp_rdy   = !flush_v && ((q.size() == 0) || (q.size() == 1 && out_ready_i));
        check("out_valid", WIDTH'(out_valid_o), WIDTH'(exp_valid));
        check("busy", WIDTH'(busy_o), WIDTH'(exp_valid));
        check("in_ready", WIDTH'(in_ready_o), WIDTH'(exp_rdy));
        if (exp_valid) begin
            check("real", out_real_o, q[0].re);
            check("imag", out_imag_o, q[0].im);
            check("idx", WIDTH'(out_idx_o), WIDTH'(q[0].idx));
            check("last", WIDTH'(out_last_o), WIDTH'(q[0].idx == SIZE - 1));
        end else begin
            check("last_idle", WIDTH'(out_last_o), '0);
        end
        if (out_valid_o && out_ready_i) dut_beats++;
        do_pop  = exp_valid && out_ready_i;
        do_push = in_valid_i && exp_rdy;
        snap    = result_i;
        @(posedge clk_i);
        if (flush_v) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                for (int i = 0; i < SIZE; i++) begin
                    b.re  = snap[2*i];
                    b.im  = snap[2*i+1];
                    b.idx = i;
                    q.push_back(b);
                end
            end
        end
        last_push = do_push;
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < SIZE; i++) begin
            result_i[2*i]   = WIDTH'(i);
            result_i[2*i+1] = WIDTH'(100 + i);
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < 2*SIZE; i++) result_i[i] = {$urandom, $urandom};
    endtask

    initial begin
        int guard;

        // Reset values while reset is held, then readiness after release.
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", WIDTH'(out_valid_o), '0);
        check("rst_busy", WIDTH'(busy_o), '0);
        check("rst_last", WIDTH'(out_last_o), '0);
        check("rst_idx", WIDTH'(out_idx_o), '0);
        check("rst_real", out_real_o, '0);
        check("rst_imag", out_imag_o, '0);
        rst_ni = 1'b1;
        #1;
        check("rst_in_ready", WIDTH'(in_ready_o), WIDTH'(1));
        @(posedge clk_i);
        #1;

        // Single ramp bundle, downstream always ready.
        dut_beats = 0;
        load_ramp();
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        cycle();
        in_valid_i = 1'b0;
        repeat (SIZE + 3) cycle();
        check("beats_single", WIDTH'(dut_beats), WIDTH'(SIZE));

        // Same bundle with a stall on every other cycle.
        dut_beats = 0;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        cycle();
        in_valid_i = 1'b0;
        for (int k = 0; k < 2*SIZE + 4; k++) begin
            out_ready_i = (k % 2 == 1);
            cycle();
        end
        check("beats_stall", WIDTH'(dut_beats), WIDTH'(SIZE));

        // Two bundles back to back: the second waits with valid high.
        dut_beats = 0;
        out_ready_i = 1'b1;
        load_random();
        in_valid_i = 1'b1;
        cycle();
        load_random();
        guard = 0;
        last_push = 1'b0;
        while (!last_push && guard < SIZE + 4) begin
            cycle();
            guard++;
        end
        check("second_accepted", WIDTH'(last_push), WIDTH'(1));
        in_valid_i = 1'b0;
        repeat (SIZE + 3) cycle();
        check("beats_b2b", WIDTH'(dut_beats), WIDTH'(2*SIZE));

        // Reset in the middle of a bundle at element 7.
        load_ramp();
        in_valid_i = 1'b1;
        cycle();
        in_valid_i = 1'b0;
        guard = 0;
        while (!(q.size() > 0 && q[0].idx == 7) && guard < SIZE + 4) begin
            cycle();
            guard++;
        end
        check("reached_idx7", WIDTH'(out_idx_o), WIDTH'(7));
        rst_ni = 1'b0;
        #1;
        check("midrst_valid", WIDTH'(out_valid_o), '0);
        check("midrst_busy", WIDTH'(busy_o), '0);
        check("midrst_real", out_real_o, '0);
        q.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        dut_beats = 0;
        load_random();
        in_valid_i = 1'b1;
        cycle();
        in_valid_i = 1'b0;
        repeat (SIZE + 3) cycle();
        check("beats_after_rst", WIDTH'(dut_beats), WIDTH'(SIZE));

`ifdef CPLX_SER_FLUSH_EN
        // Flush at element 5 while a new bundle is offered.
        load_ramp();
        in_valid_i = 1'b1;
        cycle();
        in_valid_i = 1'b0;
        guard = 0;
        while (!(q.size() > 0 && q[0].idx == 5) && guard < SIZE + 4) begin
            cycle();
            guard++;
        end
        check("reached_idx5", WIDTH'(out_idx_o), WIDTH'(5));
        load_random();
        flush_v    = 1'b1;
        in_valid_i = 1'b1;
        cycle();
        check("flush_no_accept", WIDTH'(last_push), '0);
        flush_v = 1'b0;
        cycle();
        check("accept_after_flush", WIDTH'(last_push), WIDTH'(1));
        in_valid_i = 1'b0;
        repeat (SIZE + 3) cycle();
`endif

        // Random traffic on both sides.
        for (int k = 0; k < 400; k++) begin
            in_valid_i  = ($urandom_range(0, 2) == 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            load_random();
            cycle();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (2*SIZE + 4) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
